acf_axis_packer: RTL and testbench



---
 rtl/acf_axis_packer.sv | 209 ++++++++++++++++++++
 tb/tb_acf_axis_packer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acf_axis_packer.sv
`default_nettype none
// ============================================================================
// Module   : acf_axis_packer
// Desc     : Buffers correlator words in a FWFT FIFO and repacks each frame
//            into a 32-bit AXI4-Stream packet (header, lo/hi beats, trailer).
//            Optional macro ACF_PACK_TIMESTAMP_EN adds a timestamp beat.
// Revision : 1.0
// ============================================================================
module acf_axis_packer #(
   parameter int BIN_SIZE   = 8,
   parameter int NUM_BINS   = 20,
   parameter int CNTR_SIZE  = 32,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                 CLK,
   input  logic                 rst,
   input  logic [NUM_BINS+32:0] acfEl,
   input  logic                 wrEn,
   input  logic [CNTR_SIZE-1:0] presentTime,
   output logic [31:0]          m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic                 overflow,
   output logic                 frame_done,
   output logic [15:0]          frame_seq
);

   localparam int ACF_W       = NUM_BINS + 33;
   localparam int FRAME_WORDS = 1 + BIN_SIZE * (NUM_BINS + 1);
   localparam int CNT_W       = $clog2(FRAME_WORDS);
   localparam int AW          = $clog2(FIFO_DEPTH);
   localparam int ENT_W       = ACF_W + 1;
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_WORDS - 1);
   localparam logic [AW:0]      FIFO_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_LO   = 3'd2,
      S_HI   = 3'd3,
      S_TRL  = 3'd4
`ifdef ACF_PACK_TIMESTAMP_EN
      , S_TS = 3'd5
`endif
   } state_t;

   logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic [CNT_W-1:0] in_cnt_q;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic             ovf_frame_q, ovf_frame_d;
   logic             close_pend_q, close_pend_d;
   logic             overflow_q;
   logic [15:0]      seq_q;
   logic [31:0]      trl_q;
   state_t           state_q, state_d;

   logic             w_full, w_empty, w_push, w_pop, w_drop, w_last_in, w_trl_done;
   logic [ENT_W-1:0] w_head;
   logic [31:0]      w_hi;

   assign w_full     = (count_q == FIFO_FULL);
   assign w_empty    = (count_q == '0);
   assign w_head     = mem_q[rd_ptr_q];
   assign w_last_in  = (in_cnt_q == LAST_IDX);
   // HI and TRL always present a valid beat, so tready alone marks their handshake.
   assign w_pop      = (state_q == S_HI) && m_axis_tready;
   assign w_trl_done = (state_q == S_TRL) && m_axis_tready;
   assign w_push     = wrEn && (!w_full || w_pop);
   assign w_drop     = wrEn && !w_push;

`ifdef ACF_PACK_TIMESTAMP_EN
   logic [CNTR_SIZE-1:0] ts_q;
   logic [31:0]          w_ts;

   assign w_ts = 32'(ts_q);

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         ts_q <= '0;
      end else if (w_push && (in_cnt_q == '0)) begin
         ts_q <= presentTime;
      end
   end
`else
   logic w_unused;
   assign w_unused = ^presentTime;
`endif

   always_comb begin
      w_hi = '0;
      w_hi[ACF_W-33:0] = w_head[ACF_W-1:32];
   end

   always_ff @(posedge CLK) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= {w_last_in, acfEl};
      end
   end

   // Clears happen first so that a drop in the same cycle survives the clear.
   always_comb begin
      drop_cnt_d   = drop_cnt_q;
      ovf_frame_d  = ovf_frame_q;
      close_pend_d = close_pend_q;
      if (w_trl_done) begin
         drop_cnt_d   = '0;
         ovf_frame_d  = 1'b0;
         close_pend_d = 1'b0;
      end
      if (w_drop) begin
         ovf_frame_d = 1'b1;
         if (drop_cnt_d != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_d + 16'd1;
         end
         if (w_last_in) begin
            close_pend_d = 1'b1;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!w_empty || close_pend_q) state_d = S_HDR;
         end
         S_HDR: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = {16'hACF0, seq_q};
`ifdef ACF_PACK_TIMESTAMP_EN
            if (m_axis_tready) state_d = S_TS;
         end
         S_TS: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = w_ts;
`endif
            if (m_axis_tready) state_d = S_LO;
         end
         S_LO: begin
            if (!w_empty) begin
               m_axis_tvalid = 1'b1;
               m_axis_tdata  = w_head[31:0];
               if (m_axis_tready) state_d = S_HI;
            end else if (close_pend_q) begin
               state_d = S_TRL;
            end
         end
         S_HI: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = w_hi;
            if (m_axis_tready) state_d = w_head[ENT_W-1] ? S_TRL : S_LO;
         end
         S_TRL: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = trl_q;
            m_axis_tlast  = 1'b1;
            if (m_axis_tready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         in_cnt_q     <= '0;
         drop_cnt_q   <= '0;
         ovf_frame_q  <= 1'b0;
         close_pend_q <= 1'b0;
         overflow_q   <= 1'b0;
         seq_q        <= '0;
         trl_q        <= '0;
         state_q      <= S_IDLE;
      end else begin
         state_q      <= state_d;
         drop_cnt_q   <= drop_cnt_d;
         ovf_frame_q  <= ovf_frame_d;
         close_pend_q <= close_pend_d;
         if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (w_push && !w_pop) begin
            count_q <= count_q + (AW+1)'(1);
         end else if (!w_push && w_pop) begin
            count_q <= count_q - (AW+1)'(1);
         end
         if (wrEn) in_cnt_q <= w_last_in ? '0 : in_cnt_q + CNT_W'(1);
         if (w_drop) overflow_q <= 1'b1;
         if (w_trl_done) seq_q <= seq_q + 16'd1;
         // Trailer is frozen on entry so it stays stable under backpressure.
         if ((state_d == S_TRL) && (state_q != S_TRL)) begin
            trl_q <= {ovf_frame_d, 15'd0, drop_cnt_d};
         end
      end
   end

   assign overflow   = overflow_q;
   assign frame_done = w_trl_done;
   assign frame_seq  = seq_q;

endmodule
`default_nettype wire

// File: tb/tb_acf_axis_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_acf_axis_packer
// Desc     : Directed self-checking bench for acf_axis_packer (two instances:
//            FIFO depth 64 and FIFO depth 4).
// Revision : 1.0
// ============================================================================
module tb_acf_axis_packer;

   localparam int NUM_BINS = 20;
   localparam int ACF_W    = NUM_BINS + 33;
   localparam int FW       = 169;
`ifdef ACF_PACK_TIMESTAMP_EN
   localparam int TSB = 1;
`else
   localparam int TSB = 0;
`endif

   typedef struct packed { logic [31:0] d; logic l; } beat_t;
   typedef struct {
      logic [ACF_W-1:0] word;
      logic [31:0]      exp_lo;
      logic [31:0]      exp_hi;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0]      pt;
   logic [ACF_W-1:0] el_a, el_b;
   logic             wr_a, wr_b, rdy_a, rdy_b;
   logic [31:0]      td_a, td_b;
   logic             tv_a, tv_b, tl_a, tl_b, ov_a, ov_b, fd_a, fd_b;
   logic [15:0]      sq_a, sq_b;

   acf_axis_packer #(.BIN_SIZE(8), .NUM_BINS(NUM_BINS), .CNTR_SIZE(32), .FIFO_DEPTH(64)) dut (
      .CLK(clk), .rst(rst), .acfEl(el_a), .wrEn(wr_a), .presentTime(pt),
      .m_axis_tdata(td_a), .m_axis_tvalid(tv_a), .m_axis_tready(rdy_a), .m_axis_tlast(tl_a),
      .overflow(ov_a), .frame_done(fd_a), .frame_seq(sq_a));

   acf_axis_packer #(.BIN_SIZE(8), .NUM_BINS(NUM_BINS), .CNTR_SIZE(32), .FIFO_DEPTH(4)) dut4 (
      .CLK(clk), .rst(rst), .acfEl(el_b), .wrEn(wr_b), .presentTime(pt),
      .m_axis_tdata(td_b), .m_axis_tvalid(tv_b), .m_axis_tready(rdy_b), .m_axis_tlast(tl_b),
      .overflow(ov_b), .frame_done(fd_b), .frame_seq(sq_b));

   int               total = 0;
   int               bad   = 0;
   beat_t            qa[$], qb[$];
   int               da = 0, db = 0;
   logic             st_a = 1'b0, st_b = 1'b0, sl_a, sl_b;
   logic [31:0]      sd_a, sd_b;
   logic [ACF_W-1:0] words [FW];
   logic [ACF_W-1:0] exp_w[$];
   vec_t             tbl [7];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock: observe both streams at the falling edge, return after the rising edge.
   task automatic tick();
      @(negedge clk);
      if (!rst) begin
         if (st_a) check("stall_hold_a", {94'd0, tv_a, tl_a, td_a}, {94'd0, 1'b1, sl_a, sd_a});
         if (st_b) check("stall_hold_b", {94'd0, tv_b, tl_b, td_b}, {94'd0, 1'b1, sl_b, sd_b});
         if (tv_a && rdy_a) qa.push_back({td_a, tl_a});
         if (tv_b && rdy_b) qb.push_back({td_b, tl_b});
         if (fd_a) da++;
         if (fd_b) db++;
         st_a = tv_a && !rdy_a; sd_a = td_a; sl_a = tl_a;
         st_b = tv_b && !rdy_b; sd_b = td_b; sl_b = tl_b;
      end else begin
         st_a = 1'b0;
         st_b = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   // Sends words[] one per two cycles; tready is held low until the hold-th word is presented.
   task automatic run(input int which, input int hold, input bit rnd);
      int k = 0;
      int c = 0;
      int d0;
      bit fin = 1'b0;
      d0 = (which == 0) ? da : db;
      if (which == 0) qa.delete(); else qb.delete();
      while (!fin) begin
         logic w, r;
         logic [ACF_W-1:0] e;
         w = (c % 2 == 0) && (k < FW);
         r = ((k + int'(w)) >= hold) && (!rnd || ($urandom_range(0, 9) >= 3));
         e = (k < FW) ? words[k] : '0;
         if (which == 0) begin wr_a = w; el_a = e; rdy_a = r; end
         else            begin wr_b = w; el_b = e; rdy_b = r; end
         tick();
         if (w) k++;
         c++;
         if ((k == FW) && (((which == 0) ? da : db) != d0)) fin = 1'b1;
         if (c > 5000) begin
            check("frame_timeout", 128'(c), 128'(0));
            fin = 1'b1;
         end
      end
      wr_a = 1'b0; wr_b = 1'b0;
      if (which == 0) rdy_a = 1'b1; else rdy_b = 1'b1;
      repeat (6) tick();
      if (which == 0) rdy_a = 1'b0; else rdy_b = 1'b0;
   endtask

   task automatic check_pkt(input int which, input string nm, input logic [15:0] seq,
                            input logic [31:0] trl);
      beat_t pk[$];
      int    n;
      if (which == 0) pk = qa; else pk = qb;
      n = 2 * exp_w.size() + 2 + TSB;
      check({nm, "_len"}, 128'(pk.size()), 128'(n));
      if (pk.size() != n) return;
      check({nm, "_hdr"}, 128'(pk[0]), 128'({16'hACF0, seq, 1'b0}));
`ifdef ACF_PACK_TIMESTAMP_EN
      check({nm, "_ts"}, 128'(pk[1]), 128'({pt, 1'b0}));
`endif
      for (int i = 0; i < exp_w.size(); i++) begin
         logic [ACF_W-1:0] w;
         w = exp_w[i];
         check({nm, "_payload"}, {62'd0, pk[1+TSB+2*i], pk[2+TSB+2*i]},
               {62'd0, w[31:0], 1'b0, 32'(w >> 32), 1'b0});
      end
      check({nm, "_trailer"}, 128'(pk[n-1]), 128'({trl, 1'b1}));
   endtask

   task automatic frame_counting();
      exp_w.delete();
      for (int i = 0; i < FW; i++) begin
         words[i] = ACF_W'(i);
         exp_w.push_back(ACF_W'(i));
      end
   endtask

   initial begin
      tbl[0] = '{53'h00_0000_0000_0000, 32'h0000_0000, 32'h0000_0000};
      tbl[1] = '{53'h1F_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'h001F_FFFF};
      tbl[2] = '{53'h10_0000_0000_0000, 32'h0000_0000, 32'h0010_0000};
      tbl[3] = '{53'h00_0001_0000_0000, 32'h0000_0000, 32'h0000_0001};
      tbl[4] = '{53'h00_0000_8000_0001, 32'h8000_0001, 32'h0000_0000};
      tbl[5] = '{53'h0A_BCDE_1234_5678, 32'h1234_5678, 32'h000A_BCDE};
      tbl[6] = '{53'h15_5555_AAAA_AAAA, 32'hAAAA_AAAA, 32'h0015_5555};

      pt = 32'h1234_5678;
      wr_a = 1'b0; wr_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0; el_a = '0; el_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_a", {76'd0, td_a, tv_a, tl_a, ov_a, fd_a, sq_a}, 128'd0);
      check("reset_b", {76'd0, td_b, tv_b, tl_b, ov_b, fd_b, sq_b}, 128'd0);
      rst = 1'b0;
      repeat (3) tick();
      check("idle_after_reset", {126'd0, tv_a, tv_b}, 128'd0);

      // Single frame, word k = k, no backpressure.
      frame_counting();
      run(0, 0, 1'b0);
      check_pkt(0, "full", 16'd0, 32'h0);
      if (qa.size() == 340 + TSB)
         check("full_beat337", 128'(qa[337+TSB].d), 128'(168));
      check("full_done_pulses", 128'(da), 128'(1));
      check("full_seq_ovf", {111'd0, ov_a, sq_a}, {111'd0, 1'b0, 16'd1});

      // Backpressure with table-driven head-of-frame words.
      frame_counting();
      exp_w.delete();
      for (int i = 0; i < FW; i++) begin
         if (i < 7) words[i] = tbl[i].word;
         exp_w.push_back(words[i]);
      end
      run(0, 0, 1'b1);
      check_pkt(0, "bp", 16'd1, 32'h0);
      if (qa.size() == 340 + TSB) begin
         for (int i = 0; i < 7; i++) begin
            check("bp_vec_lo", 128'(qa[1+TSB+2*i].d), 128'(tbl[i].exp_lo));
            check("bp_vec_hi", 128'(qa[2+TSB+2*i].d), 128'(tbl[i].exp_hi));
         end
      end
      check("bp_seq_ovf", {111'd0, ov_a, sq_a}, {111'd0, 1'b0, 16'd2});

      // Overflow: words 64..69 are lost while the 64-deep FIFO is full.
      frame_counting();
      exp_w.delete();
      for (int i = 0; i < FW; i++) if (i < 64 || i >= 70) exp_w.push_back(ACF_W'(i));
      run(0, 70, 1'b0);
      check_pkt(0, "ovf", 16'd2, 32'h8000_0006);
      check("ovf_sticky_seq", {111'd0, ov_a, sq_a}, {111'd0, 1'b1, 16'd3});
      check("ovf_done_pulses", 128'(da), 128'(3));

      // Async reset while the HI beat of word 0 is on the bus.
      frame_counting();
      qa.delete();
      begin
         int k = 0;
         int c = 0;
         rdy_a = 1'b1;
         while (!((qa.size() == 2 + TSB) && tv_a) && (c < 100)) begin
            wr_a = (c % 2 == 0);
            el_a = words[k];
            tick();
            if (wr_a) k++;
            c++;
         end
         check("rst_reach_hi", 128'(c < 100), 128'(1));
         wr_a = 1'b0;
         #2 rst = 1'b1;
         #1 check("rst_async", {76'd0, td_a, tv_a, tl_a, ov_a, fd_a, sq_a}, 128'd0);
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         st_a = 1'b0;
         st_b = 1'b0;
         rdy_a = 1'b0;
      end
      repeat (3) tick();
      run(0, 0, 1'b0);
      check_pkt(0, "postrst", 16'd0, 32'h0);

      // Depth-4 FIFO: the frame's last word is dropped, close comes from the pending flag.
      frame_counting();
      exp_w.delete();
      for (int i = 0; i < 4; i++) exp_w.push_back(ACF_W'(i));
      run(1, FW, 1'b0);
      check_pkt(1, "closepend", 16'd0, 32'h8000_00A5);
      check("closepend_ovf_seq", {111'd0, ov_b, sq_b}, {111'd0, 1'b1, 16'd1});
      frame_counting();
      run(1, 0, 1'b0);
      check_pkt(1, "after_close", 16'd1, 32'h0);
      check("after_close_seq", {111'd0, ov_b, sq_b}, {111'd0, 1'b1, 16'd2});
      check("depth4_done_pulses", 128'(db), 128'(2));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
